stream_demux: RTL and testbench

- Parametrised, registered 1-to-NUM_CH stream demultiplexer with valid/ready handshakes and packet framing.
- Routes each input packet to the output channel selected by S at the packet's first beat.
- Holds that route until the last beat, then re-arbitrates.
- Sits between a single producer stream and NUM_CH per-channel consumers; supersedes the fixed 8-way combinational demux.

---
 rtl/stream_demux_pkg.sv | 21 ++
 rtl/stream_demux_if.sv | 50 +++++
 rtl/stream_demux_out_reg_slice.sv | 30 +++
 rtl/stream_demux.sv | 139 +++++++++++++
 tb/tb_stream_demux.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
// Optional statistics counters are enabled with DEMUX_STATS_EN.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_t;

  // Elaboration-time ceil(log2(v)); returns at least 1 for v >= 2.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle between one producer, the demux and NUM_CH consumers.
// Statistics outputs exist only when DEMUX_STATS_EN is defined.
interface stream_demux_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8
);
  import demux_pkg::*;

  localparam int SEL_W = clog2(NUM_CH);

  logic              en;
  logic [SEL_W-1:0]  s;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  logic              busy;
  logic              err_sel;
`ifdef DEMUX_STATS_EN
  logic [31:0]       pkt_cnt;
  logic [15:0]       drop_cnt;

  modport master (
    input  en, s, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_valid, busy, err_sel,
    output pkt_cnt, drop_cnt
  );

  modport slave (
    output en, s, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_valid, busy, err_sel,
    input  pkt_cnt, drop_cnt
  );
`else
  modport master (
    input  en, s, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_valid, busy, err_sel
  );

  modport slave (
    output en, s, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_valid, busy, err_sel
  );
`endif

endinterface

// File: rtl/stream_demux_out_reg_slice.sv
// One-deep output register: holds {channel, last, data} until the selected
// consumer drains it; load and drain in the same cycle keep full throughput.
module out_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         reg_valid,
  output logic         free
);

  assign free = !reg_valid || drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_valid <= 1'b0;
      q         <= '0;
    end else if (load) begin
      reg_valid <= 1'b1;
      q         <= d;
    end else if (drain) begin
      reg_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_CH packet demux; route chosen on the first beat, held to the last.
// DEMUX_STATS_EN adds packet and dropped-packet counters.
//
// state | meaning
// IDLE  | between packets; en and s sampled on the next accepted beat
// PKT   | packet in progress, beats follow the latched select
// DROP  | packet with out-of-range select, beats discarded until last
module stream_demux
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8
) (
  input  logic          clk,
  input  logic          rst,
  stream_demux_if.master bus
);

  localparam int SEL_W = clog2(NUM_CH);
  localparam int W     = SEL_W + 1 + DATA_W;
  localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

  state_t            state, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  load_ch;
  logic              load;
  logic              in_ready_c;
  logic              err_d, err_q;
  logic              s_ok;
  logic              drain;
  logic              reg_valid;
  logic              free;
  logic [W-1:0]      word_q;
  logic [SEL_W-1:0]  reg_ch;
  logic [NUM_CH-1:0] out_valid_c;

  assign s_ok = {1'b0, bus.s} < NUM_CH_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      sel_q <= sel_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    state_d    = state;
    sel_d      = sel_q;
    in_ready_c = 1'b0;
    load       = 1'b0;
    load_ch    = sel_q;
    err_d      = 1'b0;
    unique case (state)
      IDLE: begin
        // Bad selects are swallowed even when the register is full.
        in_ready_c = bus.en && (s_ok ? free : 1'b1);
        if (bus.in_valid && in_ready_c) begin
          if (s_ok) begin
            sel_d   = bus.s;
            load    = 1'b1;
            load_ch = bus.s;
            if (!bus.in_last) state_d = PKT;
          end else begin
            err_d = 1'b1;
            if (!bus.in_last) state_d = DROP;
          end
        end
      end
      PKT: begin
        in_ready_c = free;
        if (bus.in_valid && in_ready_c) begin
          load = 1'b1;
          if (bus.in_last) state_d = IDLE;
        end
      end
      DROP: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && bus.in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  out_reg_slice #(.W(W)) u_slice (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .drain     (drain),
    .d         ({load_ch, bus.in_last, bus.in_data}),
    .q         (word_q),
    .reg_valid (reg_valid),
    .free      (free)
  );

  assign reg_ch = word_q[W-1 -: SEL_W];

  // Only the held channel's ready can drain the register.
  always_comb begin
    out_valid_c = '0;
    drain       = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (reg_ch == SEL_W'(i)) begin
        out_valid_c[i] = reg_valid;
        drain          = bus.out_ready[i];
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = word_q[DATA_W-1:0];
  assign bus.out_last  = word_q[DATA_W];
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = (state == PKT);
  assign bus.err_sel   = err_q;

`ifdef DEMUX_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (load && bus.in_last) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (err_d) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.pkt_cnt  = pkt_cnt_q;
  assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: an 8-channel and a 6-channel instance.
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_demux_if #(.DATA_W(8), .NUM_CH(8)) if8 ();
  stream_demux_if #(.DATA_W(8), .NUM_CH(6)) if6 ();

  stream_demux #(.DATA_W(8), .NUM_CH(8)) u8 (.clk(clk), .rst(rst), .bus(if8.master));
  stream_demux #(.DATA_W(8), .NUM_CH(6)) u6 (.clk(clk), .rst(rst), .bus(if6.master));

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t q8[$];
  exp_t q6[$];
  int   checks = 0;
  int   errors = 0;
  bit   pkt8 = 0;
  int   sel8 = 0;
  int   pkts8 = 0;
  bit   pkt6 = 0;
  bit   drop6 = 0;
  int   sel6 = 0;
  int   err6 = 0;

  // Output monitors: pop the scoreboard on every completed output transfer.
  exp_t m8;
  exp_t m6;
  logic [7:0] ev8;
  logic [5:0] ev6;
  always @(negedge clk) begin
    if (!rst) begin
      if (if8.out_valid != 0) begin
        checks++;
        if (!$onehot(if8.out_valid)) begin
          errors++;
          $display("FAIL onehot8: out_valid=%b", if8.out_valid);
        end
        if ((if8.out_valid & if8.out_ready) != 0) begin
          checks++;
          if (q8.size() == 0) begin
            errors++;
            $display("FAIL extra8: out_valid=%b data=%h with empty scoreboard", if8.out_valid, if8.out_data);
          end else begin
            m8  = q8.pop_front();
            ev8 = 8'(1 << m8.ch);
            if (if8.out_valid !== ev8 || if8.out_data !== m8.data || if8.out_last !== m8.last) begin
              errors++;
              $display("FAIL beat8: got valid=%b data=%h last=%b exp valid=%b data=%h last=%b",
                       if8.out_valid, if8.out_data, if8.out_last, ev8, m8.data, m8.last);
            end
          end
        end
      end
      if (if6.out_valid != 0 && (if6.out_valid & if6.out_ready) != 0) begin
        checks++;
        if (q6.size() == 0) begin
          errors++;
          $display("FAIL extra6: out_valid=%b data=%h with empty scoreboard", if6.out_valid, if6.out_data);
        end else begin
          m6  = q6.pop_front();
          ev6 = 6'(1 << m6.ch);
          if (if6.out_valid !== ev6 || if6.out_data !== m6.data || if6.out_last !== m6.last) begin
            errors++;
            $display("FAIL beat6: got valid=%b data=%h last=%b exp valid=%b data=%h last=%b",
                     if6.out_valid, if6.out_data, if6.out_last, ev6, m6.data, m6.last);
          end
        end
      end
      if (if6.err_sel) err6++;
      if (if8.err_sel) begin
        checks++;
        errors++;
        $display("FAIL err8: err_sel=1 exp 0");
      end
    end
  end

  task automatic send8(input logic [7:0] d, input logic last, input logic [2:0] s, output int waits);
    bit done;
    int ch;
    exp_t e;
    if8.in_valid = 1'b1;
    if8.in_data  = d;
    if8.in_last  = last;
    if8.s        = s;
    waits = 0;
    done  = 0;
    while (!done) begin
      @(negedge clk);
      if (if8.in_ready) begin
        ch = pkt8 ? sel8 : int'(s);
        e.ch = ch; e.data = d; e.last = last;
        q8.push_back(e);
        if (last) begin
          pkt8 = 0;
          pkts8++;
        end else begin
          pkt8 = 1;
          sel8 = ch;
        end
        done = 1;
      end else begin
        waits++;
        if (waits > 50) begin
          checks++;
          errors++;
          $display("FAIL send8_timeout: in_ready=%b after %0d cycles exp 1", if8.in_ready, waits);
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    if8.in_valid = 1'b0;
  endtask

  task automatic send6(input logic [7:0] d, input logic last, input logic [2:0] s, output int waits);
    bit done;
    exp_t e;
    if6.in_valid = 1'b1;
    if6.in_data  = d;
    if6.in_last  = last;
    if6.s        = s;
    waits = 0;
    done  = 0;
    while (!done) begin
      @(negedge clk);
      if (if6.in_ready) begin
        if (!pkt6) begin
          drop6 = (int'(s) >= 6);
          sel6  = int'(s);
        end
        if (!drop6) begin
          e.ch = sel6; e.data = d; e.last = last;
          q6.push_back(e);
        end
        pkt6 = !last;
        if (last) drop6 = 0;
        done = 1;
      end else begin
        waits++;
        if (waits > 50) begin
          checks++;
          errors++;
          $display("FAIL send6_timeout: in_ready=%b after %0d cycles exp 1", if6.in_ready, waits);
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    if6.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (if8.out_valid !== 8'h00) begin errors++; $display("FAIL rst_valid: got %b exp 0", if8.out_valid); end
    checks++; if (if8.out_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h exp 00", if8.out_data); end
    checks++; if (if8.out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b exp 0", if8.out_last); end
    checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", if8.busy); end
    checks++; if (if8.err_sel !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", if8.err_sel); end
    checks++; if (if6.out_valid !== 6'h00) begin errors++; $display("FAIL rst_valid6: got %b exp 0", if6.out_valid); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b exp 1", if8.in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int w;
    send8(8'hA5, 1'b1, 3'd3, w);
    @(negedge clk);
    checks++; if (if8.out_valid !== 8'b0000_1000) begin errors++; $display("FAIL single_valid: got %b exp 00001000", if8.out_valid); end
    checks++; if (if8.out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h exp a5", if8.out_data); end
    checks++; if (if8.out_last !== 1'b1) begin errors++; $display("FAIL single_last: got %b exp 1", if8.out_last); end
    @(negedge clk);
    checks++; if (if8.out_valid !== 8'h00) begin errors++; $display("FAIL single_drained: got %b exp 0", if8.out_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_multi_beat();
    int w;
    send8(8'h10, 1'b0, 3'd5, w);
    for (int i = 1; i < 4; i++) begin
      checks++; if (if8.busy !== 1'b1) begin errors++; $display("FAIL multi_busy%0d: got %b exp 1", i, if8.busy); end
      send8(8'h10 + 8'(i), (i == 3), 3'd1, w);
      checks++; if (w !== 0) begin errors++; $display("FAIL multi_rate%0d: got %0d waits exp 0", i, w); end
    end
    checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL multi_idle: busy got %b exp 0", if8.busy); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (q8.size() !== 0) begin errors++; $display("FAIL multi_drain: %0d beats outstanding exp 0", q8.size()); end
  endtask

  task automatic test_stall();
    int w;
    send8(8'h20, 1'b0, 3'd2, w);
    send8(8'h21, 1'b0, 3'd2, w);
    if8.out_ready = 8'hFB;
    if8.in_valid  = 1'b1;
    if8.in_data   = 8'h22;
    if8.in_last   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++; if (if8.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b exp 0", if8.in_ready); end
      checks++; if (if8.out_data !== 8'h21) begin errors++; $display("FAIL stall_data: got %h exp 21", if8.out_data); end
      checks++; if (if8.out_valid !== 8'h04) begin errors++; $display("FAIL stall_valid: got %b exp 00000100", if8.out_valid); end
    end
    @(posedge clk);
    #1 if8.out_ready = 8'hFF;
    for (int i = 2; i < 5; i++) begin
      send8(8'h20 + 8'(i), (i == 4), 3'd2, w);
      checks++; if (w !== 0) begin errors++; $display("FAIL stall_resume%0d: got %0d waits exp 0", i, w); end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (q8.size() !== 0) begin errors++; $display("FAIL stall_drain: %0d beats outstanding exp 0", q8.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] dt [5] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
    logic       lt [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] st [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd7};
    int w;
    for (int i = 0; i < 5; i++) begin
      send8(dt[i], lt[i], st[i], w);
      checks++; if (w !== 0) begin errors++; $display("FAIL b2b_bubble%0d: got %0d waits exp 0", i, w); end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (q8.size() !== 0) begin errors++; $display("FAIL b2b_drain: %0d beats outstanding exp 0", q8.size()); end
  endtask

  task automatic test_drop();
    int w;
    err6 = 0;
    for (int i = 0; i < 3; i++) begin
      send6(8'h40 + 8'(i), (i == 2), (i == 0) ? 3'd7 : 3'd3, w);
      checks++; if (w !== 0) begin errors++; $display("FAIL drop_ready%0d: got %0d waits exp 0", i, w); end
      checks++; if (if6.busy !== 1'b0) begin errors++; $display("FAIL drop_busy%0d: got %b exp 0", i, if6.busy); end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (err6 !== 1) begin errors++; $display("FAIL drop_err: got %0d pulses exp 1", err6); end
    send6(8'h43, 1'b1, 3'd4, w);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (q6.size() !== 0) begin errors++; $display("FAIL drop_drain6: %0d beats outstanding exp 0", q6.size()); end
`ifdef DEMUX_STATS_EN
    checks++; if (if6.drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_cnt: got %0d exp 1", if6.drop_cnt); end
    checks++; if (if6.pkt_cnt !== 32'd1) begin errors++; $display("FAIL pkt_cnt6: got %0d exp 1", if6.pkt_cnt); end
`endif
  endtask

  task automatic test_enable();
    int w;
    send8(8'h50, 1'b0, 3'd6, w);
    if8.en = 1'b0;
    send8(8'h51, 1'b0, 3'd6, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL en_mid1: got %0d waits exp 0", w); end
    send8(8'h52, 1'b1, 3'd6, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL en_mid2: got %0d waits exp 0", w); end
    if8.in_valid = 1'b1;
    if8.in_data  = 8'h53;
    if8.in_last  = 1'b1;
    if8.s        = 3'd1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (if8.in_ready !== 1'b0) begin errors++; $display("FAIL en_block: got %b exp 0", if8.in_ready); end
    end
    @(posedge clk);
    #1 if8.en = 1'b1;
    send8(8'h53, 1'b1, 3'd1, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL en_resume: got %0d waits exp 0", w); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (q8.size() !== 0) begin errors++; $display("FAIL en_drain: %0d beats outstanding exp 0", q8.size()); end
  endtask

  task automatic test_reset_mid();
    int w;
    if8.out_ready = 8'hEF;
    send8(8'h60, 1'b0, 3'd4, w);
    @(negedge clk);
    checks++; if (if8.busy !== 1'b1) begin errors++; $display("FAIL rm_busy_pre: got %b exp 1", if8.busy); end
    checks++; if (if8.out_valid !== 8'h10) begin errors++; $display("FAIL rm_held: got %b exp 00010000", if8.out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (if8.out_valid !== 8'h00) begin errors++; $display("FAIL rm_valid: got %b exp 0", if8.out_valid); end
    checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b exp 0", if8.busy); end
    q8.delete();
    pkt8  = 0;
    pkts8 = 0;
    if8.out_ready = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send8(8'h61, 1'b1, 3'd0, w);
    @(negedge clk);
    checks++; if (if8.out_valid !== 8'h01) begin errors++; $display("FAIL rm_route_valid: got %b exp 00000001", if8.out_valid); end
    checks++; if (if8.out_data !== 8'h61) begin errors++; $display("FAIL rm_route_data: got %h exp 61", if8.out_data); end
    repeat (2) @(posedge clk);
    #1;
`ifdef DEMUX_STATS_EN
    checks++; if (if8.pkt_cnt !== 32'(pkts8)) begin errors++; $display("FAIL pkt_cnt8: got %0d exp %0d", if8.pkt_cnt, pkts8); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    if8.en        = 1'b1;
    if8.s         = '0;
    if8.in_data   = '0;
    if8.in_valid  = 1'b0;
    if8.in_last   = 1'b0;
    if8.out_ready = 8'hFF;
    if6.en        = 1'b1;
    if6.s         = '0;
    if6.in_data   = '0;
    if6.in_valid  = 1'b0;
    if6.in_last   = 1'b0;
    if6.out_ready = 6'h3F;

    test_reset();
    test_single();
    test_multi_beat();
    test_stall();
    test_back_to_back();
    test_drop();
    test_enable();
    test_reset_mid();

    checks++; if (q8.size() !== 0) begin errors++; $display("FAIL final_q8: %0d beats outstanding exp 0", q8.size()); end
    checks++; if (q6.size() !== 0) begin errors++; $display("FAIL final_q6: %0d beats outstanding exp 0", q6.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
